uart_boot_loader: RTL

- Serial boot loader. Receives a framed image over a UART RX line and writes it into simple RAM as a bus initiator.
- Drives the same device_select/addr/we/oe/data bus that RAM and peripherals respond to.
- Holds the CPU off the bus (cpu_hold) until a frame is accepted, then releases it.

---
 rtl/uart_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// Serial boot loader. Receives a framed image on a UART RX line
// (SYNC, ADDR_H, ADDR_L, LEN, LEN data bytes, CSUM) and writes the data bytes
// into RAM as a bus initiator. The CPU is held off the bus until a frame is
// accepted with a good checksum.
//
// Optional feature macro: LOADER_READBACK_EN
//   When defined, every write is followed by a one-cycle VERIFY read of the
//   same address; a readback mismatch aborts the frame with err_code 3.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx                  UART serial input (idle high, asynchronous)
//   start               one-cycle pulse, re-arms the loader from DONE
//   bus_device_select   device select (RAM_DEVICE during access, else IDLE_DEVICE)
//   bus_addr            bus address (0 outside an access)
//   bus_we / bus_oe     write / output enable
//   bus_data_out        write data
//   bus_data_in         read data (readback only)
//   cpu_hold            high while the loader owns the bus
//   busy                high from SYNC accepted until DONE/ERR
//   done / error        sticky success / error flags
//   err_code            0 none, 1 framing, 2 checksum, 3 readback
module uart_boot_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [2:0] RAM_DEVICE   = 3'b001,
  parameter logic [2:0] IDLE_DEVICE  = 3'b000,
  parameter logic [7:0] SYNC_BYTE    = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        start,
  output logic [2:0]  bus_device_select,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic        bus_oe,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic          byte_valid, frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_meta_reg  <= rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        // Edge rather than level detect, so a line stuck low after a
        // framing error does not retrigger reception.
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == CNT_HALF) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;  // high = glitch
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == CNT_FULL) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};  // LSB first
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == CNT_FULL) begin
          byte_valid    = rx_sync_reg;
          frame_err     = !rx_sync_reg;
          rx_state_next = RX_IDLE;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  typedef enum logic [3:0] {
    S_WAIT_SYNC, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_WRITE,
`ifdef LOADER_READBACK_EN
    S_VERIFY,
`endif
    S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  count_reg, count_next;
  logic [7:0]  sum_reg, sum_next;
  logic [7:0]  data_reg, data_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic        cpu_hold_reg, cpu_hold_next;
  logic        go_err, advance;
  logic [1:0]  go_err_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_WAIT_SYNC;
      addr_reg     <= '0;
      count_reg    <= '0;
      sum_reg      <= '0;
      data_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      err_code_reg <= 2'd0;
      cpu_hold_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      sum_reg      <= sum_next;
      data_reg     <= data_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
      err_code_reg <= err_code_next;
      cpu_hold_reg <= cpu_hold_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    sum_next      = sum_reg;
    data_next     = data_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    error_next    = error_reg;
    err_code_next = err_code_reg;
    cpu_hold_next = cpu_hold_reg;
    go_err        = 1'b0;
    go_err_code   = 2'd0;
    advance       = 1'b0;
    case (state_reg)
      S_WAIT_SYNC: begin
        if (byte_valid && rx_shift_reg == SYNC_BYTE) begin
          error_next    = 1'b0;
          err_code_next = 2'd0;
          busy_next     = 1'b1;
          sum_next      = '0;
          state_next    = S_ADDR_H;
        end
      end
      S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM: begin
        if (frame_err) begin
          go_err      = 1'b1;
          go_err_code = 2'd1;
        end else if (byte_valid) begin
          sum_next = sum_reg + rx_shift_reg;
          case (state_reg)
            S_ADDR_H: begin
              addr_next[15:8] = rx_shift_reg;
              state_next      = S_ADDR_L;
            end
            S_ADDR_L: begin
              addr_next[7:0] = rx_shift_reg;
              state_next     = S_LEN;
            end
            S_LEN: begin
              count_next = rx_shift_reg;
              state_next = (rx_shift_reg == 8'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
              data_next  = rx_shift_reg;
              state_next = S_WRITE;
            end
            default: begin  // S_CSUM
              sum_next = sum_reg;
              if (rx_shift_reg == sum_reg) begin
                busy_next     = 1'b0;
                done_next     = 1'b1;
                cpu_hold_next = 1'b0;
                state_next    = S_DONE;
              end else begin
                go_err      = 1'b1;
                go_err_code = 2'd2;
              end
            end
          endcase
        end
      end
`ifdef LOADER_READBACK_EN
      S_WRITE: state_next = S_VERIFY;
      S_VERIFY: begin
        if (bus_data_in != data_reg) begin
          go_err      = 1'b1;
          go_err_code = 2'd3;
        end else begin
          advance = 1'b1;
        end
      end
`else
      S_WRITE: advance = 1'b1;
`endif
      S_DONE: begin
        if (start) begin
          done_next     = 1'b0;
          cpu_hold_next = 1'b1;
          state_next    = S_WAIT_SYNC;
        end
      end
      S_ERR:   state_next = S_WAIT_SYNC;
      default: state_next = S_WAIT_SYNC;
    endcase

    if (advance) begin
      addr_next  = addr_reg + 16'd1;  // wraps FFFF -> 0000
      count_next = count_reg - 8'd1;
      state_next = (count_reg == 8'd1) ? S_CSUM : S_DATA;
    end
    if (go_err) begin
      state_next    = S_ERR;
      error_next    = 1'b1;
      err_code_next = go_err_code;
      busy_next     = 1'b0;
    end
  end

  // ---------------- Bus and status outputs ----------------
  logic access;
`ifdef LOADER_READBACK_EN
  assign access = (state_reg == S_WRITE) || (state_reg == S_VERIFY);
  assign bus_oe = (state_reg == S_VERIFY);
`else
  assign access = (state_reg == S_WRITE);
  assign bus_oe = 1'b0;
  logic unused_data_in;
  assign unused_data_in = ^bus_data_in;
`endif
  assign bus_we            = (state_reg == S_WRITE);
  assign bus_device_select = access ? RAM_DEVICE : IDLE_DEVICE;
  assign bus_addr          = access ? addr_reg : 16'd0;
  assign bus_data_out      = data_reg;
  assign cpu_hold          = cpu_hold_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign error             = error_reg;
  assign err_code          = err_code_reg;
endmodule
